instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 29 ++
 rtl/instr_sequencer_imm_extend.sv | 20 ++
 rtl/instr_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the bit positions of the instruction fields.
package instr_sequencer_pkg;

    localparam logic [5:0] OP_NOP        = 6'b000000;
    localparam logic [5:0] OP_LDI        = 6'b010000;
    localparam logic [5:0] OP_LUI        = 6'b010001;
    localparam logic [5:0] OP_LB         = 6'b100000;
    localparam logic [4:0] OP_BRANCH_PFX = 5'b01111;   // BEQ 011110, BLT 011111

    localparam int OPC_LSB  = 26;
    localparam int REG1_LSB = 21;
    localparam int REG2_LSB = 16;
    localparam int REG3_LSB = 11;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    function automatic logic is_branch(input logic [5:0] op);
        return op[5:1] == OP_BRANCH_PFX;
    endfunction

endpackage

// File: rtl/instr_sequencer_imm_extend.sv
// Immediate extension: LDI/LUI zero-extend imm16, everything else sign-extends.
// Purely combinational, no handshake.
module imm_extend
    import instr_sequencer_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [15:0] imm16,
    output logic [31:0] imm
);

    always_comb begin
        imm = {{16{imm16[15]}}, imm16};
        case (opcode)
            OP_LDI, OP_LUI: imm = {16'h0000, imm16};
            OP_LB:          imm = {{16{imm16[15]}}, imm16};   // byte-load offsets are signed
            default:        imm = {{16{imm16[15]}}, imm16};
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Decode/read/execute/write sequencer: one instruction in flight, 5 cycles with a
// first-cycle alu_done; instr_ready is low while busy, so fetch simply holds off.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [5:0]  opcode,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  reg3,
    output logic [31:0] imm,
    output logic        reg_read,
    output logic        reg_write,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   instr_q;
    logic [CW-1:0] exec_cnt;
    logic          exec_last;

    assign opcode    = instr_q[OPC_LSB  +: 6];
    assign reg1      = instr_q[REG1_LSB +: 5];
    assign reg2      = instr_q[REG2_LSB +: 5];
    assign reg3      = instr_q[REG3_LSB +: 5];
    assign busy      = (state != S_IDLE);
    assign exec_last = (exec_cnt == CW'(ALU_TIMEOUT - 1));

    imm_extend u_imm_extend (
        .opcode (opcode),
        .imm16  (instr_q[IMM_LSB +: 16]),
        .imm    (imm)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        reg_read    = 1'b0;
        reg_write   = 1'b0;
        alu_start   = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = (opcode == OP_NOP) ? S_IDLE : S_READ;
            S_READ: begin
                reg_read  = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_start = (exec_cnt == '0);
                if (alu_done)       state_nxt = is_branch(opcode) ? S_IDLE : S_WRITE;
                else if (exec_last) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                reg_write = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Strobes stay quiet for the whole time reset is held, whatever state we were in.
        if (reset) begin
            instr_ready = 1'b0;
            reg_read    = 1'b0;
            reg_write   = 1'b0;
            alu_start   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= '0;
            write_data  <= '0;
            exec_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE && instr_valid) instr_q <= instr;
            if (state == S_EXEC) begin
                exec_cnt <= exec_cnt + CW'(1);
                if (alu_done)       write_data  <= alu_result;
                else if (exec_last) timeout_err <= 1'b1;
            end else begin
                exec_cnt <= '0;
            end
        end
    end

endmodule
